// File: rtl/bit_reverse_buffer.sv
// ---------------------------------------------------------------------------
// bit_reverse_buffer
//
// Reorders FFT output frames from bit-reversed bin order to natural bin order.
// Two N-word ping-pong banks (each word holds re and im). Incoming samples are
// written at the bit-reversed address of their arrival index. A completed
// bank is read out in natural address order while the other bank fills.
//
// Ports:
//   clock   - master clock, rising edge
//   reset   - synchronous active-high reset
//   di_en   - input sample valid
//   di_re   - input sample real part (bit-reversed bin order)
//   di_im   - input sample imaginary part
//   do_en   - output sample valid (registered)
//   do_sof  - high with output index 0 of each frame
//   do_re   - output sample real part (natural bin order), 0 when idle
//   do_im   - output sample imaginary part, 0 when idle
//
// Latency: when the last sample of a frame is captured at edge E, output
// index m is presented after edge E+2+m. Back-to-back frames give an
// uninterrupted do_en.
// ---------------------------------------------------------------------------
module bit_reverse_buffer #(
    parameter int N     = 64,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic             do_sof,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_cnt_reg;
    logic          wr_bank_reg;
    logic [AW-1:0] wr_addr_rev;
    logic          wr_last;

    // Bit-reversed write address: arrival index k lands at bin bitrev(k).
    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_rev
            assign wr_addr_rev[gi] = wr_cnt_reg[AW-1-gi];
        end
    endgenerate

    // Last sample of a frame accepted on this edge: launch the readout.
    assign wr_last = di_en && (wr_cnt_reg == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_cnt_reg  <= '0;
            wr_bank_reg <= 1'b0;
        end else if (di_en) begin
            // N is a power of two, so the counter wraps to 0 by itself.
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
            if (wr_cnt_reg == LAST) begin
                wr_bank_reg <= ~wr_bank_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank storage: both banks in one array, bank select is the address MSB.
    // No reset; contents are meaningless until written.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] mem [0:2*N-1];
    logic [2*WIDTH-1:0] rd_word_reg;

    always_ff @(posedge clock) begin
        if (di_en && !reset) begin
            mem[{wr_bank_reg, wr_addr_rev}] <= {di_re, di_im};
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    state_t        state_reg, state_next;
    logic [AW-1:0] rd_cnt_reg, rd_cnt_next;
    logic          rd_bank_reg, rd_bank_next;
    logic          rd_en;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            rd_cnt_reg  <= '0;
            rd_bank_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rd_cnt_reg  <= rd_cnt_next;
            rd_bank_reg <= rd_bank_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rd_cnt_next  = rd_cnt_reg;
        rd_bank_next = rd_bank_reg;
        rd_en        = (state_reg == READ);

        if (state_reg == READ) begin
            if (rd_cnt_reg == LAST) begin
                state_next  = IDLE;
                rd_cnt_next = '0;
            end else begin
                rd_cnt_next = rd_cnt_reg + 1'b1;
            end
        end

        // A launch always wins: it can only coincide with the final read
        // address of the previous frame, so frames chain without a gap.
        if (wr_last) begin
            state_next   = READ;
            rd_cnt_next  = '0;
            rd_bank_next = wr_bank_reg;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: registered RAM read, then registered outputs.
    // ------------------------------------------------------------------
    logic rd_valid_reg;
    logic rd_first_reg;

    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_word_reg <= mem[{rd_bank_reg, rd_cnt_reg}];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_reg <= 1'b0;
            rd_first_reg <= 1'b0;
            do_en        <= 1'b0;
            do_sof       <= 1'b0;
            do_re        <= '0;
            do_im        <= '0;
        end else begin
            rd_valid_reg <= rd_en;
            rd_first_reg <= rd_en && (rd_cnt_reg == '0);
            do_en        <= rd_valid_reg;
            do_sof       <= rd_valid_reg && rd_first_reg;
            // Data is forced to zero outside valid cycles.
            do_re        <= rd_valid_reg ? rd_word_reg[2*WIDTH-1:WIDTH] : '0;
            do_im        <= rd_valid_reg ? rd_word_reg[WIDTH-1:0]       : '0;
        end
    end

endmodule

// File: tb/tb_bit_reverse_buffer.sv
// Testbench for bit_reverse_buffer: an N=64 instance runs directed frames
// (ramp, back-to-back, gapped, reset mid-frame, reset mid-readout, random)
// and an N=4 instance runs 100 random frames with random gaps. A reference
// model turns each completed input frame into the expected natural-order
// output list, stamped with the cycle it must appear in; monitors pop and
// compare on every cycle.
module tb_bit_reverse_buffer;

    localparam int W  = 16;
    localparam int NA = 64;
    localparam int NB = 4;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         sof;
        int           cyc;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset_a, a_en, a_do_en, a_do_sof;
    logic [W-1:0] a_re, a_im, a_do_re, a_do_im;
    logic         reset_b, b_en, b_do_en, b_do_sof;
    logic [W-1:0] b_re, b_im, b_do_re, b_do_im;

    bit_reverse_buffer #(.N(NA), .WIDTH(W)) dut_a (
        .clock (clock),
        .reset (reset_a),
        .di_en (a_en),
        .di_re (a_re),
        .di_im (a_im),
        .do_en (a_do_en),
        .do_sof(a_do_sof),
        .do_re (a_do_re),
        .do_im (a_do_im)
    );

    bit_reverse_buffer #(.N(NB), .WIDTH(W)) dut_b (
        .clock (clock),
        .reset (reset_b),
        .di_en (b_en),
        .di_re (b_re),
        .di_im (b_im),
        .do_en (b_do_en),
        .do_sof(b_do_sof),
        .do_re (b_do_re),
        .do_im (b_do_im)
    );

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_on = 1'b0;

    exp_t         q_a[$];
    exp_t         q_b[$];
    logic [W-1:0] fa_re[$], fa_im[$], fb_re[$], fb_im[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Reverse the low 'bits' bits of v.
    function automatic int brev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) r = r * 2 + ((v >> i) & 1);
        return r;
    endfunction

    // One clock of stimulus for instance A plus the reference model update.
    // The sample is captured at edge cyc+1, so output m of a frame completed
    // here is due at cycle cyc+3+m.
    task automatic step_a(input logic rst, input logic en,
                          input logic [W-1:0] re, input logic [W-1:0] im);
        reset_a = rst; a_en = en; a_re = re; a_im = im;
        if (rst) begin
            fa_re.delete(); fa_im.delete();
            while (q_a.size() > 0 && q_a[$].cyc > cyc) void'(q_a.pop_back());
        end else if (en) begin
            fa_re.push_back(re); fa_im.push_back(im);
            if (fa_re.size() == NA) begin
                for (int m = 0; m < NA; m++) begin
                    exp_t e;
                    e.re = fa_re[brev(m, 6)]; e.im = fa_im[brev(m, 6)];
                    e.sof = (m == 0); e.cyc = cyc + 3 + m;
                    q_a.push_back(e);
                end
                fa_re.delete(); fa_im.delete();
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic step_b(input logic rst, input logic en,
                          input logic [W-1:0] re, input logic [W-1:0] im);
        reset_b = rst; b_en = en; b_re = re; b_im = im;
        if (rst) begin
            fb_re.delete(); fb_im.delete();
            while (q_b.size() > 0 && q_b[$].cyc > cyc) void'(q_b.pop_back());
        end else if (en) begin
            fb_re.push_back(re); fb_im.push_back(im);
            if (fb_re.size() == NB) begin
                for (int m = 0; m < NB; m++) begin
                    exp_t e;
                    e.re = fb_re[brev(m, 2)]; e.im = fb_im[brev(m, 2)];
                    e.sof = (m == 0); e.cyc = cyc + 3 + m;
                    q_b.push_back(e);
                end
                fb_re.delete(); fb_im.delete();
            end
        end
        @(posedge clock); #1;
    endtask

    // Monitors sample on the falling edge.
    always @(negedge clock) begin
        exp_t e;
        if (mon_on) begin
            checks++;
            if (a_do_en) begin
                if (q_a.size() == 0) begin
                    failures++;
                    $display("FAIL a_unexpected cyc=%0d got re=%h im=%h sof=%b, required no output",
                             cyc, a_do_re, a_do_im, a_do_sof);
                end else begin
                    e = q_a.pop_front();
                    if (e.cyc != cyc || e.re != a_do_re || e.im != a_do_im || e.sof != a_do_sof) begin
                        failures++;
                        $display("FAIL a_out cyc=%0d got re=%h im=%h sof=%b, required cyc=%0d re=%h im=%h sof=%b",
                                 cyc, a_do_re, a_do_im, a_do_sof, e.cyc, e.re, e.im, e.sof);
                    end else begin
                        $display("a out cyc=%0d re=%h im=%h sof=%b ok", cyc, a_do_re, a_do_im, a_do_sof);
                    end
                end
            end else begin
                if (a_do_sof || a_do_re != '0 || a_do_im != '0) begin
                    failures++;
                    $display("FAIL a_idle cyc=%0d got sof=%b re=%h im=%h, required all 0",
                             cyc, a_do_sof, a_do_re, a_do_im);
                end
                if (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
                    failures++;
                    $display("FAIL a_missing cyc=%0d got do_en=0, required re=%h im=%h at cyc=%0d",
                             cyc, q_a[0].re, q_a[0].im, q_a[0].cyc);
                    void'(q_a.pop_front());
                end
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (mon_on) begin
            checks++;
            if (b_do_en) begin
                if (q_b.size() == 0) begin
                    failures++;
                    $display("FAIL b_unexpected cyc=%0d got re=%h im=%h sof=%b, required no output",
                             cyc, b_do_re, b_do_im, b_do_sof);
                end else begin
                    e = q_b.pop_front();
                    if (e.cyc != cyc || e.re != b_do_re || e.im != b_do_im || e.sof != b_do_sof) begin
                        failures++;
                        $display("FAIL b_out cyc=%0d got re=%h im=%h sof=%b, required cyc=%0d re=%h im=%h sof=%b",
                                 cyc, b_do_re, b_do_im, b_do_sof, e.cyc, e.re, e.im, e.sof);
                    end else begin
                        $display("b out cyc=%0d re=%h im=%h sof=%b ok", cyc, b_do_re, b_do_im, b_do_sof);
                    end
                end
            end else begin
                if (b_do_sof || b_do_re != '0 || b_do_im != '0) begin
                    failures++;
                    $display("FAIL b_idle cyc=%0d got sof=%b re=%h im=%h, required all 0",
                             cyc, b_do_sof, b_do_re, b_do_im);
                end
                if (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
                    failures++;
                    $display("FAIL b_missing cyc=%0d got do_en=0, required re=%h im=%h at cyc=%0d",
                             cyc, q_b[0].re, q_b[0].im, q_b[0].cyc);
                    void'(q_b.pop_front());
                end
            end
        end
    end

    initial begin
        int guard;
        reset_a = 1'b1; a_en = 1'b0; a_re = '0; a_im = '0;
        reset_b = 1'b1; b_en = 1'b0; b_re = '0; b_im = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (a_do_en || a_do_sof || a_do_re != '0 || a_do_im != '0 ||
            b_do_en || b_do_sof || b_do_re != '0 || b_do_im != '0) begin
            failures++;
            $display("FAIL reset_state got a_en=%b a_sof=%b a_re=%h a_im=%h b_en=%b, required all 0",
                     a_do_en, a_do_sof, a_do_re, a_do_im, b_do_en);
        end
        mon_on = 1'b1;

        fork
            begin : seq_a
                step_a(1'b1, 1'b0, '0, '0);
                // Ramp frame: re=k, im=-k.
                for (int k = 0; k < NA; k++) step_a(1'b0, 1'b1, W'(k), W'(-k));
                repeat (70) step_a(1'b0, 1'b0, '0, '0);
                // Three frames back-to-back.
                for (int k = 0; k < 3 * NA; k++) step_a(1'b0, 1'b1, W'($urandom), W'($urandom));
                repeat (70) step_a(1'b0, 1'b0, '0, '0);
                // Ramp frame with alternating gaps.
                for (int k = 0; k < NA; k++) begin
                    step_a(1'b0, 1'b1, W'(k), W'(-k));
                    step_a(1'b0, 1'b0, '0, '0);
                end
                repeat (70) step_a(1'b0, 1'b0, '0, '0);
                // Reset after 40 samples (sample on the reset edge is dropped).
                for (int k = 0; k < 40; k++) step_a(1'b0, 1'b1, W'($urandom), W'($urandom));
                step_a(1'b1, 1'b1, W'($urandom), W'($urandom));
                for (int k = 0; k < NA; k++) step_a(1'b0, 1'b1, W'($urandom), W'($urandom));
                repeat (70) step_a(1'b0, 1'b0, '0, '0);
                // Reset right after output index 10 is shown.
                for (int k = 0; k < NA; k++) step_a(1'b0, 1'b1, W'($urandom), W'($urandom));
                repeat (12) step_a(1'b0, 1'b0, '0, '0);
                step_a(1'b1, 1'b0, '0, '0);
                repeat (80) step_a(1'b0, 1'b0, '0, '0);
                // Random frames with random gaps.
                for (int k = 0; k < 8 * NA; k++) begin
                    while ($urandom_range(0, 3) == 0) step_a(1'b0, 1'b0, '0, '0);
                    step_a(1'b0, 1'b1, W'($urandom), W'($urandom));
                end
                repeat (10) step_a(1'b0, 1'b0, '0, '0);
            end
            begin : seq_b
                step_b(1'b1, 1'b0, '0, '0);
                for (int k = 0; k < 100 * NB; k++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        repeat ($urandom_range(1, 3)) step_b(1'b0, 1'b0, '0, '0);
                    end
                    step_b(1'b0, 1'b1, W'($urandom), W'($urandom));
                end
                repeat (10) step_b(1'b0, 1'b0, '0, '0);
            end
        join

        guard = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && guard < 2000) begin
            @(posedge clock);
            guard++;
        end
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            failures++;
            $display("FAIL drain got pending a=%0d b=%0d, required 0 0", q_a.size(), q_b.size());
        end
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
